// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 sequencing controller.
// Phase lengths are expressed as the last beat index of each state.
package rc4_pkg;

    localparam int N_ENT_DEF = 16;
    localparam int NIB_W_DEF = 4;
    localparam int CNT_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT_S = 3'd1,
        ST_LOAD_K = 3'd2,
        ST_KSA    = 3'd3,
        ST_COPY   = 3'd4,
        ST_PRGA   = 3'd5,
        ST_DONE   = 3'd6
    } rc4_state_e;

    // Last beat index of a counted phase; KSA and PRGA take two cycles per step.
    function automatic logic [CNT_W-1:0] phase_last(input rc4_state_e st,
                                                    input int n_ent,
                                                    input logic [7:0] ks);
        logic [CNT_W-1:0] last;
        last = '0;
        case (st)
            ST_INIT_S: last = CNT_W'(n_ent / 2 - 1);
            ST_LOAD_K: last = CNT_W'(n_ent - 1);
            ST_KSA:    last = CNT_W'(2 * n_ent - 1);
            ST_COPY:   last = CNT_W'(n_ent - 1);
            ST_PRGA:   last = {ks, 1'b0} - CNT_W'(1);
            default:   last = '0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/rc4_beat_cnt.sv
// Loadable beat up-counter with a terminal-count flag against a supplied last index.
module rc4_beat_cnt
    import rc4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_last,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_inc)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/rc4_seq_ctrl.sv
// Sequencer for one RC4 pass: S init, key load, KSA, S copy, PRGA keystream, done.
// All controls decode from the registered state and beat count; only en_k/in_k follow key_valid.
module rc4_seq_ctrl
    import rc4_pkg::*;
#(
    parameter int N_ENT = N_ENT_DEF,
    parameter int NIB_W = NIB_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       ks_count,
    input  logic             key_valid,
    input  logic [NIB_W-1:0] key_nib,
    output logic             key_ready,
    output logic             en_s,
    output logic             en_k,
    output logic             enc,
    output logic             en_mod,
    output logic [NIB_W-1:0] in1s,
    output logic [NIB_W-1:0] in2s,
    output logic [NIB_W-1:0] in_k,
    output logic             clk_rst,
    output logic             rst_i,
    output logic             rst_s,
    output logic             rst_j,
    output logic             rst_copy,
    output logic             rst_prga,
    output logic             rst_final,
    output logic             busy,
    output logic             done,
    output logic             ks_valid,
    output logic [2:0]       state_o
);

    rc4_state_e       r_state;
    rc4_state_e       w_next;
    logic [7:0]       r_ks;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_hs;
    logic             w_inc;
    logic             w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ks    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start)
                r_ks <= ks_count;
        end
    end

    assign w_hs   = (r_state == ST_LOAD_K) && key_valid;
    assign w_load = (w_next != r_state);
    assign w_inc  = (r_state != ST_IDLE) && (r_state != ST_DONE) &&
                    ((r_state != ST_LOAD_K) || w_hs);

    rc4_beat_cnt u_beat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_load_val ('0),
        .i_last     (phase_last(r_state, N_ENT, r_ks)),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_INIT_S;
            ST_INIT_S: if (w_tc) w_next = ST_LOAD_K;
            ST_LOAD_K: if (w_hs && w_tc) w_next = ST_KSA;
            ST_KSA:    if (w_tc) w_next = ST_COPY;
            ST_COPY:   if (w_tc) w_next = (r_ks == 8'd0) ? ST_DONE : ST_PRGA;
            ST_PRGA:   if (w_tc) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        key_ready = (r_state == ST_LOAD_K);
        en_s      = (r_state == ST_INIT_S);
        en_k      = w_hs;
        enc       = (r_state == ST_COPY);
        en_mod    = (r_state == ST_PRGA);
        in1s      = '0;
        in2s      = '0;
        in_k      = w_hs ? key_nib : '0;
        if (r_state == ST_INIT_S) begin
            in1s = NIB_W'(w_cnt << 1);
            in2s = NIB_W'((w_cnt << 1) | CNT_W'(1));
        end
        clk_rst   = !(r_state inside {ST_KSA, ST_COPY, ST_PRGA});
        rst_j     = !(r_state inside {ST_KSA, ST_COPY, ST_PRGA});
        // i pointer restarts for the copy sweep, so it is pulsed on COPY entry
        rst_i     = !((r_state == ST_KSA) || (r_state == ST_PRGA) ||
                      ((r_state == ST_COPY) && (w_cnt != '0)));
        rst_s     = !(r_state inside {ST_INIT_S, ST_LOAD_K, ST_KSA, ST_COPY, ST_PRGA});
        rst_copy  = (r_state != ST_COPY);
        rst_prga  = (r_state != ST_PRGA);
        rst_final = (r_state != ST_PRGA);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        ks_valid  = (r_state == ST_PRGA) && w_cnt[0];
        state_o   = r_state;
    end

endmodule

// File: tb/tb_rc4_seq_ctrl.sv
// Directed bench for rc4_seq_ctrl: phase lengths, handshake stalls, skip, re-start and reset.
module tb_rc4_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ks_count;
    logic       key_valid;
    logic [3:0] key_nib;
    logic       key_ready, en_s, en_k, enc, en_mod;
    logic [3:0] in1s, in2s, in_k;
    logic       clk_rst, rst_i, rst_s, rst_j, rst_copy, rst_prga, rst_final;
    logic       busy, done, ks_valid;
    logic [2:0] state_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rc4_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ks_count(ks_count),
        .key_valid(key_valid), .key_nib(key_nib), .key_ready(key_ready),
        .en_s(en_s), .en_k(en_k), .enc(enc), .en_mod(en_mod),
        .in1s(in1s), .in2s(in2s), .in_k(in_k),
        .clk_rst(clk_rst), .rst_i(rst_i), .rst_s(rst_s), .rst_j(rst_j),
        .rst_copy(rst_copy), .rst_prga(rst_prga), .rst_final(rst_final),
        .busy(busy), .done(done), .ks_valid(ks_valid), .state_o(state_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_pass(input logic [7:0] ks, input int stall_at, input int stall_len,
                            input bit repulse, input string tg);
        int n_init, n_load, n_enk, n_ksa, n_ksa_free, n_copy, n_copy_ri;
        int n_prga, n_ksv, n_bad, n_done_hi, cyc, prev_st, last_st, n_extra;
        bit seen;
        logic [2:0] st;
        n_init = 0; n_load = 0; n_enk = 0; n_ksa = 0; n_ksa_free = 0; n_copy = 0;
        n_copy_ri = 0; n_prga = 0; n_ksv = 0; n_bad = 0; n_done_hi = 0;
        prev_st = 0; last_st = 0; seen = 0; n_extra = 0;
        @(negedge clk);
        ks_count = ks;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ks_count = 8'hA5;
        cyc = 1;
        while (!seen && cyc < 2000) begin
            st = state_o;
            key_valid = !(st == 3'd2 && n_load >= stall_at && n_load < stall_at + stall_len);
            key_nib = 4'(cyc * 7);
            start = repulse && ((st == 3'd5 && n_prga == 0) || st == 3'd6);
            #1;
            case (st)
                3'd1: begin
                    if (in1s != 4'(2 * n_init) || in2s != 4'(2 * n_init + 1) || !en_s) n_bad++;
                    n_init++;
                end
                3'd2: begin
                    n_load++;
                    if (!key_ready) n_bad++;
                    if (en_k) begin
                        n_enk++;
                        if (in_k != key_nib) n_bad++;
                    end
                end
                3'd3: begin
                    n_ksa++;
                    if (!clk_rst && !rst_i && !rst_j) n_ksa_free++;
                end
                3'd4: begin
                    n_copy++;
                    if (rst_i) n_copy_ri++;
                    if (!enc || rst_copy) n_bad++;
                end
                3'd5: begin
                    if (ks_valid != n_prga[0]) n_bad++;
                    if (ks_valid) n_ksv++;
                    if (!en_mod || rst_prga || rst_final) n_bad++;
                    n_prga++;
                end
                3'd6: begin
                    seen = 1'b1;
                    n_done_hi = done;
                    last_st = prev_st;
                    if (!clk_rst || !rst_i || !rst_s || !rst_prga) n_bad++;
                end
                default: n_bad++;
            endcase
            if (st != 3'd2 && (en_k || in_k != 4'd0)) n_bad++;
            if (st != 3'd1 && (in1s != 4'd0 || in2s != 4'd0)) n_bad++;
            if (st != 3'd6 && done) n_bad++;
            if (!busy) n_bad++;
            if (!seen) begin
                prev_st = st;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk({tg, "_reached_done"}, seen, 1);
        chk({tg, "_init_cycles"}, n_init, 8);
        chk({tg, "_load_cycles"}, n_load, 16 + stall_len);
        chk({tg, "_en_k_beats"}, n_enk, 16);
        chk({tg, "_ksa_cycles"}, n_ksa, 32);
        chk({tg, "_ksa_resets_free"}, n_ksa_free, 32);
        chk({tg, "_copy_cycles"}, n_copy, 16);
        chk({tg, "_copy_rst_i_pulse"}, n_copy_ri, 1);
        chk({tg, "_prga_cycles"}, n_prga, 2 * int'(ks));
        chk({tg, "_ks_valid_pulses"}, n_ksv, int'(ks));
        chk({tg, "_bad_beats"}, n_bad, 0);
        chk({tg, "_done_high"}, n_done_hi, 1);
        chk({tg, "_done_cycle"}, cyc, 73 + stall_len + 2 * int'(ks));
        chk({tg, "_state_before_done"}, last_st, (ks == 8'd0) ? 4 : 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tg, "_idle_after_done"}, state_o, 0);
        for (int i = 0; i < 6; i++) begin
            if (done || busy || state_o != 3'd0) n_extra++;
            @(posedge clk);
            #1;
        end
        chk({tg, "_no_second_done"}, n_extra, 0);
    endtask

    task automatic reset_mid_ksa();
        int n_ksa, n_bad, cyc;
        n_ksa = 0; n_bad = 0; cyc = 0;
        @(negedge clk);
        ks_count = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (n_ksa < 10 && cyc < 200) begin
            if (state_o == 3'd3) n_ksa++;
            if (n_ksa < 10) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("rst_reached_ksa10", n_ksa, 10);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_state_idle", state_o, 0);
        chk("rst_clk_rst", clk_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_enables", {en_s, en_k, enc, en_mod, ks_valid, done}, 0);
        chk("rst_resets", {rst_i, rst_s, rst_j, rst_copy, rst_prga, rst_final}, 6'h3F);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_bad++;
        end
        chk("rst_no_done_after", n_bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ks_count = 8'd0;
        key_valid = 1'b1;
        key_nib = 4'd0;
        #3;
        chk("reset_state", state_o, 0);
        chk("reset_busy", busy, 0);
        chk("reset_enables", {key_ready, en_s, en_k, enc, en_mod, ks_valid, done}, 0);
        chk("reset_resets", {clk_rst, rst_i, rst_s, rst_j, rst_copy, rst_prga, rst_final}, 7'h7F);
        chk("reset_data", {in1s, in2s, in_k}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start", state_o, 0);

        run_pass(8'd4, 0, 0, 1'b0, "ks4");
        run_pass(8'd4, 5, 5, 1'b0, "stall5");
        run_pass(8'd0, 0, 0, 1'b0, "ks0");
        run_pass(8'd3, 0, 0, 1'b1, "repulse");
        reset_mid_ksa();
        run_pass(8'd1, 0, 0, 1'b0, "after_rst");
        run_pass(8'd255, 3, 2, 1'b0, "ks255");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
